// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-lane time-division demultiplexer.
// Takes a serial stream of slot-ordered beats (slot 0 flagged by sof) and
// presents each completed frame as one registered lane vector.
// Optional build macro: FRAME_CNT_EN adds an 8-bit completed-frame counter
// output (frame_cnt).
//
// state | meaning
// HUNT  | searching for an sof beat; non-sof beats are discarded
// SYNC  | aligned; slot tracks the next expected slot index
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 sof,
    output logic [4*WIDTH-1:0]   out,
    output logic                 frame_valid,
    output logic [1:0]           slot,
    output logic                 locked,
    output logic                 sync_err
`ifdef FRAME_CNT_EN
    ,
    output logic [7:0]           frame_cnt
`endif
);

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_slot;
    logic [1:0]         w_slot_nxt;
    logic               r_locked;
    logic [WIDTH-1:0]   r_shadow0;
    logic [WIDTH-1:0]   r_shadow1;
    logic [WIDTH-1:0]   r_shadow2;
    logic [4*WIDTH-1:0] r_out;
    logic               r_frame_valid;
    logic               r_sync_err;
    logic               w_load0;
    logic               w_load_mid;
    logic               w_frame_done;
    logic               w_err;

    // Next-state, slot advance and beat routing decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_slot_nxt   = r_slot;
        w_load0      = 1'b0;
        w_load_mid   = 1'b0;
        w_frame_done = 1'b0;
        w_err        = 1'b0;
        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (sof) begin
                        w_load0     = 1'b1;
                        w_slot_nxt  = 2'd1;
                        w_state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (sof) begin
                        // An sof beat always restarts the frame; it is only
                        // a violation when a frame was partly collected.
                        w_load0    = 1'b1;
                        w_slot_nxt = 2'd1;
                        w_err      = (r_slot != 2'd0);
                    end else if (r_slot == 2'd0) begin
                        w_err       = 1'b1;
                        w_slot_nxt  = 2'd0;
                        w_state_nxt = HUNT;
                    end else if (r_slot == 2'd3) begin
                        w_frame_done = 1'b1;
                        w_slot_nxt   = 2'd0;
                    end else begin
                        w_load_mid = 1'b1;
                        w_slot_nxt = r_slot + 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_slot_nxt  = 2'd0;
                end
            endcase
        end
    end

    // State, slot pointer and lock indication registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= HUNT;
            r_slot   <= 2'd0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_slot   <= w_slot_nxt;
            r_locked <= (w_state_nxt == SYNC);
        end
    end

    // Shadow lanes collect slots 0..2; slot 3 goes straight to the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow0 <= '0;
            r_shadow1 <= '0;
            r_shadow2 <= '0;
        end else begin
            if (w_load0)
                r_shadow0 <= din;
            if (w_load_mid && (r_slot == 2'd1))
                r_shadow1 <= din;
            if (w_load_mid && (r_slot == 2'd2))
                r_shadow2 <= din;
        end
    end

    // Whole-frame output update and single-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out         <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= w_frame_done;
            r_sync_err    <= w_err;
            if (w_frame_done)
                r_out <= {din, r_shadow2, r_shadow1, r_shadow0};
        end
    end

`ifdef FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    // Completed-frame counter, updated alongside out so the two stay consistent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_frame_cnt <= 8'd0;
        else if (w_frame_done)
            r_frame_cnt <= r_frame_cnt + 8'd1;
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign out         = r_out;
    assign frame_valid = r_frame_valid;
    assign slot        = r_slot;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=1). Inputs change on the falling edge;
// outputs are compared on the following falling edge.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] din;
    logic       din_valid;
    logic       sof;
    logic [3:0] out;
    logic       frame_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;
`ifdef FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    tdm_demux4 #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .out         (out),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
`ifdef FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic s, input logic d);
        din_valid = 1'b1;
        sof       = s;
        din       = d;
        @(negedge clk);
    endtask

    task automatic idle();
        din_valid = 1'b0;
        sof       = 1'b0;
        din       = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [8:0] pat;
        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        sof       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out", out, 4'h0);
        chk("rst_slot", slot, 2'd0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_err", sync_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1,0,1,1 from reset
        beat(1'b1, 1'b1);
        chk("t1_lock_first", locked, 1'b1);
        chk("t1_slot_first", slot, 2'd1);
        chk("t1_fv_first", frame_valid, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        chk("t1_fv_early", frame_valid, 1'b0);
        beat(1'b0, 1'b1);
        chk("t1_out", out, 4'hD);
        chk("t1_fv", frame_valid, 1'b1);
        chk("t1_slot", slot, 2'd0);
        chk("t1_locked", locked, 1'b1);
        chk("t1_err", sync_err, 1'b0);
        idle();
        chk("t1_fv_pulse", frame_valid, 1'b0);
        chk("t1_out_hold", out, 4'hD);
`ifdef FRAME_CNT_EN
        chk("t1_cnt", frame_cnt, 8'd1);
`endif

        // Non-sof beat at slot 0 while locked
        beat(1'b0, 1'b1);
        chk("t5_err", sync_err, 1'b1);
        chk("t5_locked", locked, 1'b0);
        chk("t5_out", out, 4'hD);
        chk("t5_slot", slot, 2'd0);
        chk("t5_fv", frame_valid, 1'b0);
        idle();
        chk("t5_err_pulse", sync_err, 1'b0);

        // Non-sof beats in HUNT are discarded
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 1'b1);
            chk("t2_hunt_fv", frame_valid, 1'b0);
            chk("t2_hunt_err", sync_err, 1'b0);
        end
        chk("t2_hunt_locked", locked, 1'b0);
        chk("t2_hunt_slot", slot, 2'd0);
        chk("t2_hunt_out", out, 4'hD);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        chk("t2_out", out, 4'h2);
        chk("t2_fv", frame_valid, 1'b1);
        chk("t2_locked", locked, 1'b1);

        // All-ones frame, then a frame spread across gaps
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b1);
        chk("t3_out_ones", out, 4'hF);
        beat(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t3_gap_out", out, 4'hF);
            chk("t3_gap_fv", frame_valid, 1'b0);
        end
        chk("t3_gap_slot", slot, 2'd1);
        beat(1'b0, 1'b0);
        idle();
        chk("t3_gap2_slot", slot, 2'd2);
        beat(1'b0, 1'b1);
        chk("t3_fv_early", frame_valid, 1'b0);
        chk("t3_out_early", out, 4'hF);
        chk("t3_slot3", slot, 2'd3);
        beat(1'b0, 1'b0);
        chk("t3_out", out, 4'h4);
        chk("t3_fv", frame_valid, 1'b1);

        // sof arriving mid-frame restarts the frame
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b0);
        chk("t4_err", sync_err, 1'b1);
        chk("t4_locked", locked, 1'b1);
        chk("t4_slot", slot, 2'd1);
        chk("t4_fv", frame_valid, 1'b0);
        chk("t4_out_hold", out, 4'h4);
        beat(1'b0, 1'b1);
        chk("t4_err_pulse", sync_err, 1'b0);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b1);
        chk("t4_out", out, 4'hE);
        chk("t4_fv", frame_valid, 1'b1);
        chk("t4_err_clr", sync_err, 1'b0);

        // Asynchronous reset mid-frame
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        chk("t6_slot_pre", slot, 2'd2);
        din_valid = 1'b0;
        sof       = 1'b0;
        rst       = 1'b1;
        #1;
        chk("t6_out", out, 4'h0);
        chk("t6_slot", slot, 2'd0);
        chk("t6_locked", locked, 1'b0);
        chk("t6_fv", frame_valid, 1'b0);
        chk("t6_err", sync_err, 1'b0);
`ifdef FRAME_CNT_EN
        chk("t6_cnt", frame_cnt, 8'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        beat(1'b0, 1'b1);
        chk("t6_hunt_slot", slot, 2'd0);
        chk("t6_hunt_locked", locked, 1'b0);

        // 300 back-to-back frames
        for (int i = 0; i < 300; i++) begin
            pat = 9'(i);
            beat(1'b1, pat[0]);
            beat(1'b0, pat[1]);
            beat(1'b0, pat[2]);
            beat(1'b0, pat[3]);
            if (i == 150) begin
                chk("b2b_fv", frame_valid, 1'b1);
                chk("b2b_out", out, 4'h6);
            end
        end
        chk("b2b_last_out", out, 4'hB);
        chk("b2b_last_fv", frame_valid, 1'b1);
        idle();
        chk("b2b_fv_end", frame_valid, 1'b0);
`ifdef FRAME_CNT_EN
        chk("cnt_wrap", frame_cnt, 8'd44);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
Time-division demultiplexer, 4 lanes. Receives one serial lane stream of slot-ordered beats (slot 0..3, slot 0 flagged by sof) and distributes each beat to its lane register. Presents all 4 lanes as one registered vector per completed frame. Far-end counterpart of the team's 4x1 mux used as a TDM serializer.

Parameters:
WIDTH, 1, bits per lane/beat (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
din  input  WIDTH  serial beat data
din_valid  input  1  beat present this cycle
sof  input  1  start of frame; qualifies din as slot 0; ignored when din_valid=0
out  output  4*WIDTH  lane vector; lane k at out[k*WIDTH +: WIDTH]
frame_valid  output  1  one-cycle pulse: out updated with a new frame
slot  output  2  next slot index expected
locked  output  1  1 = SYNC state
sync_err  output  1  one-cycle pulse: framing violation detected

Behaviour:
- Reset (async, any time incl. mid-frame): state=HUNT, slot=0, shadow lanes=0, out=0, frame_valid=0, sync_err=0, locked=0. Partial frame discarded.
- Beat = cycle with din_valid=1. Cycles with din_valid=0 hold all state; frame_valid/sync_err deassert.
- FSM, 2 states:
  - HUNT: beat with sof=0 -> discarded, stay. Beat with sof=1 -> shadow[0]<=din, slot<=1, go SYNC.
  - SYNC, slot=0: beat with sof=1 -> shadow[0]<=din, slot<=1. Beat with sof=0 -> sync_err pulse, go HUNT, slot<=0, beat discarded.
  - SYNC, slot=1 or 2: beat with sof=0 -> shadow[slot]<=din, slot<=slot+1. Beat with sof=1 -> sync_err pulse, partial frame discarded, beat taken as new slot 0 (shadow[0]<=din, slot<=1), stay SYNC.
  - SYNC, slot=3: beat with sof=0 -> out<={din, shadow[2], shadow[1], shadow[0]}, frame_valid=1 next cycle, slot wraps to 0. Beat with sof=1 -> same as slot 1/2 violation.
- Latency: out and frame_valid change on the edge that accepts the slot-3 beat; both visible the following cycle. frame_valid exactly one cycle even if the next frame starts immediately.
- out holds its last value between frames and during HUNT/errors; never partially updated.
- Back-to-back frames (4 consecutive beats each, no gaps) sustained at 1 frame per 4 cycles.
- sync_err and frame_valid never assert in the same cycle.
- locked registered, equals (state==SYNC).

Optional Feature:
FRAME_CNT_EN: when defined, adds output port frame_cnt (8 bits) counting completed frames; increments on each frame_valid pulse, wraps 255->0, reset 0, unaffected by sync_err. When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then frame WIDTH=1, beats (sof=1,din=1),(0),(1),(1) consecutive -> out=4'b1101, frame_valid single pulse cycle after 4th beat, slot=0, locked=1.
- Beats with sof=0 while HUNT (din=1 x3) then a valid frame 0,1,0,0 -> no frame_valid for first 3, then out=4'b0010.
- SYNC, frame 1,1,1,1 then gaps: beats 0,(gap 3 cycles),0,(gap),1,0 -> out=4'b0100 only after 4th beat; out stays 4'b1111 during gaps.
- Mid-frame sof: sof beat din=1, beat din=1, then sof beat din=0, then 1,1,1 -> sync_err pulse on 3rd beat, locked stays 1, out=4'b1110.
- SYNC slot 0 beat with sof=0 -> sync_err pulse, locked=0, out unchanged, following non-sof beats ignored until sof.
- Assert rst mid-frame after 2 beats -> all outputs 0 immediately (async); with FRAME_CNT_EN, 300 consecutive frames -> frame_cnt=44.
